// File: rtl/xpb_lut_gen_if.sv
// xpb_lut_gen_if: control and read-bus bundle for xpb_lut_gen.
//   start/base/modulus   generation request and operands
//   busy/done/ready/err  generator status
//   rd_en/rd_idx         per-channel read requests (channel c at [c*IDX_W +: IDX_W])
//   rd_valid/rd_data     per-channel registered read results (channel c at [c*DATA_W +: DATA_W])
// master drives requests, slave (the generator) drives status and read data.
interface xpb_lut_gen_if #(
  parameter int DATA_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_RD = 1
);
  logic                       start;
  logic [DATA_W-1:0]          base;
  logic [DATA_W-1:0]          modulus;
  logic                       busy;
  logic                       done;
  logic                       ready;
  logic                       err;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*IDX_W-1:0]    rd_idx;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_RD*DATA_W-1:0]   rd_data;

  modport master (
    output start, base, modulus, rd_en, rd_idx,
    input  busy, done, ready, err, rd_valid, rd_data
  );

  modport slave (
    input  start, base, modulus, rd_en, rd_idx,
    output busy, done, ready, err, rd_valid, rd_data
  );
endinterface

// File: rtl/xpb_lut.sv
// xpb_lut_gen: builds entry[k] = (k * base) mod modulus for k = 0..DEPTH-1,
// one entry per cycle, then serves the table to NUM_RD registered read ports.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    xpb_lut_gen_if.slave (start/base/modulus in, busy/done/ready/err out,
//          rd_en/rd_idx in, rd_valid/rd_data out)

// One registered read channel: captures the addressed entry when the read
// is accepted, otherwise holds the last returned data.
module xpb_lut_rd #(
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= en_i & ready_i;
      if (en_i && ready_i) data_q <= rdata_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

module xpb_lut_gen #(
  parameter int DATA_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_RD = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  xpb_lut_gen_if.slave  bus
);
  localparam int DEPTH = 2**IDX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] b_q, b_d, m_q, m_d, acc_q, acc_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d, done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W:0]   sum, red;
  logic              accept, bad;

  always_comb begin
    // acc < M and B < M, so one conditional subtract keeps the result < M
    sum    = {1'b0, acc_q} + {1'b0, b_q};
    red    = (sum >= {1'b0, m_q}) ? sum - {1'b0, m_q} : sum;
    accept = bus.start && (state_q != S_GEN);
    bad    = (bus.base >= bus.modulus) || (bus.modulus == '0);

    state_d = state_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = red[DATA_W-1:0];

    if (accept) begin
      b_d   = bus.base;
      m_d   = bus.modulus;
      err_d = bad;
      if (bad) begin
        state_d = S_IDLE;
      end else begin
        we      = 1'b1;
        waddr   = '0;
        wdata   = '0;
        acc_d   = '0;
        cnt_d   = IDX_W'(1);
        state_d = S_GEN;
      end
    end else if (state_q == S_GEN) begin
      we    = 1'b1;
      acc_d = red[DATA_W-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH-1)) begin
        state_d = S_READY;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Table storage has no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.busy  = (state_q == S_GEN);
  assign bus.ready = (state_q == S_READY);
  assign bus.done  = done_q;
  assign bus.err   = err_q;

  logic [NUM_RD-1:0][IDX_W-1:0]  rd_idx;
  logic [NUM_RD-1:0]             rd_vld;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_dat;

  assign rd_idx       = bus.rd_idx;
  assign bus.rd_valid = rd_vld;
  assign bus.rd_data  = rd_dat;

  // A read coinciding with a restart sees the old table: ready is still
  // high this cycle and the generator's first write lands at the same edge.
  for (genvar c = 0; c < NUM_RD; c++) begin : g_rd
    xpb_lut_rd #(.DATA_W(DATA_W)) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.rd_en[c]),
      .ready_i (bus.ready),
      .rdata_i (mem_q[rd_idx[c]]),
      .valid_o (rd_vld[c]),
      .data_o  (rd_dat[c])
    );
  end
endmodule

// File: tb/tb_xpb_lut_gen.sv
module tb_xpb_lut_gen;
  typedef logic [1023:0] wide_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Small configuration: 16-bit entries, 8-entry table, two read channels
  xpb_lut_gen_if #(.DATA_W(16), .IDX_W(3), .NUM_RD(2)) s_if ();
  xpb_lut_gen #(.DATA_W(16), .IDX_W(3), .NUM_RD(2)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));

  // Default configuration
  xpb_lut_gen_if l_if ();
  xpb_lut_gen u_l (.clk(clk), .rst_n(rst_n), .bus(l_if.slave));

  int n_run  = 0;
  int n_fail = 0;

  typedef struct { logic [2:0] i0, i1; logic [15:0] x0, x1; } rd_vec_t;
  rd_vec_t tbl [6];

  typedef struct { int ch; logic [15:0] data; } sb_t;
  sb_t   sbq [$];
  wide_t sbq_l [$];
  logic [15:0] last_d [2];

  wide_t Bl, Ml;

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act[127:0], exp[127:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare read outputs with what the bench queued for this cycle
  task automatic sb_drain;
    logic [1:0] ev;
    sb_t e;
    ev = '0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      ev[e.ch] = 1'b1;
      last_d[e.ch] = e.data;
    end
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rd_valid%0d", c), wide_t'(s_if.rd_valid[c]), wide_t'(ev[c]));
      chk($sformatf("rd_data%0d", c), wide_t'(s_if.rd_data[c*16 +: 16]), wide_t'(last_d[c]));
    end
  endtask

  task automatic rd2(input logic [2:0] i0, input logic [2:0] i1, input logic e0,
                     input logic e1, input logic exp_ok,
                     input logic [15:0] x0, input logic [15:0] x1);
    s_if.rd_idx = {i1, i0};
    s_if.rd_en  = {e1, e0};
    if (exp_ok && e0) sbq.push_back('{ch: 0, data: x0});
    if (exp_ok && e1) sbq.push_back('{ch: 1, data: x1});
    tick();
    s_if.rd_en = '0;
    sb_drain();
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] m);
    s_if.base    = b;
    s_if.modulus = m;
    s_if.start   = 1'b1;
    tick();
    s_if.start   = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!s_if.done && cyc < maxc) begin
      tick();
      cyc++;
    end
    if (!s_if.done) begin
      n_run++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", maxc);
    end
  endtask

  function automatic wide_t gold(input int k);
    logic [1028:0] p;
    p = {5'b0, Bl} * 1029'(k);
    return wide_t'(p % {5'b0, Ml});
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  wide_t'(s_if.busy),  '0);
    chk({tag, "_done"},  wide_t'(s_if.done),  '0);
    chk({tag, "_ready"}, wide_t'(s_if.ready), '0);
    chk({tag, "_err"},   wide_t'(s_if.err),   '0);
    chk({tag, "_rdv"},   wide_t'(s_if.rd_valid), '0);
    chk({tag, "_rdd"},   wide_t'(s_if.rd_data),  '0);
  endtask

  initial begin
    int bcnt, dcnt, dat, cyc;
    logic any;

    tbl[0] = '{3'd0, 3'd1, 16'h0000, 16'h9000};
    tbl[1] = '{3'd2, 3'd3, 16'h200F, 16'hB00F};
    tbl[2] = '{3'd4, 3'd5, 16'h401E, 16'hD01E};
    tbl[3] = '{3'd6, 3'd7, 16'h602D, 16'hF02D};
    tbl[4] = '{3'd7, 3'd0, 16'hF02D, 16'h0000};
    tbl[5] = '{3'd3, 3'd3, 16'hB00F, 16'hB00F};

    Ml = {32{32'hD00DFEED}};
    Bl = {32{32'h12345679}};

    s_if.start = 1'b0; s_if.base = '0; s_if.modulus = '0;
    s_if.rd_en = '0;   s_if.rd_idx = '0;
    l_if.start = 1'b0; l_if.base = '0; l_if.modulus = '0;
    l_if.rd_en = '0;   l_if.rd_idx = '0;
    last_d[0] = '0; last_d[1] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // First generation: busy 7 cycles, single done pulse 8 cycles after start
    do_start(16'h9000, 16'hFFF1);
    bcnt = 0; dcnt = 0; dat = 0;
    for (int off = 1; off <= 12; off++) begin
      if (s_if.busy) bcnt++;
      if (s_if.done) begin dcnt++; dat = off; end
      tick();
    end
    chk("gen_busy_cycles", wide_t'(bcnt), wide_t'(7));
    chk("gen_done_at",     wide_t'(dat),  wide_t'(8));
    chk("gen_done_pulses", wide_t'(dcnt), wide_t'(1));
    chk("gen_ready",       wide_t'(s_if.ready), wide_t'(1));
    chk("gen_err",         wide_t'(s_if.err),   wide_t'(0));

    // Table-driven dual-channel reads
    foreach (tbl[i]) rd2(tbl[i].i0, tbl[i].i1, 1'b1, 1'b1, 1'b1, tbl[i].x0, tbl[i].x1);
    rd2(3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 16'hD01E, 16'h0000);

    // Restart in READY with simultaneous read of idx 2 -> old table value
    s_if.base = 16'h0001; s_if.modulus = 16'hFFF1; s_if.start = 1'b1;
    s_if.rd_idx = {3'd7, 3'd2}; s_if.rd_en = 2'b01;
    sbq.push_back('{ch: 0, data: 16'h200F});
    tick();
    s_if.start = 1'b0; s_if.rd_en = '0;
    sb_drain();
    chk("restart_ready", wide_t'(s_if.ready), wide_t'(0));
    chk("restart_busy",  wide_t'(s_if.busy),  wide_t'(1));

    // Read and an out-of-range start during GEN: both ignored
    s_if.base = 16'h1234; s_if.modulus = 16'h1000; s_if.start = 1'b1;
    rd2(3'd6, 3'd1, 1'b1, 1'b1, 1'b0, '0, '0);
    s_if.start = 1'b0;
    chk("gen_start_ign_err", wide_t'(s_if.err),  wide_t'(0));
    chk("gen_start_ign_bsy", wide_t'(s_if.busy), wide_t'(1));
    wait_done(20, cyc);
    chk("regen_done_lat", wide_t'(cyc), wide_t'(6));
    rd2(3'd5, 3'd7, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007);

    // Bad operands: err set, ready dropped, never busy
    do_start(16'h1234, 16'h1000);
    chk("bad_err",   wide_t'(s_if.err),   wide_t'(1));
    chk("bad_ready", wide_t'(s_if.ready), wide_t'(0));
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any |= s_if.busy;
      tick();
    end
    chk("bad_no_busy", wide_t'(any), wide_t'(0));
    rd2(3'd1, 3'd1, 1'b1, 1'b1, 1'b0, '0, '0);
    do_start(16'h0000, 16'h0000);
    chk("zero_mod_err", wide_t'(s_if.err), wide_t'(1));
    do_start(16'h9000, 16'hFFF1);
    chk("good_clr_err", wide_t'(s_if.err),  wide_t'(0));
    chk("good_busy",    wide_t'(s_if.busy), wide_t'(1));
    wait_done(20, cyc);
    rd2(3'd4, 3'd2, 1'b1, 1'b1, 1'b1, 16'h401E, 16'h200F);

    // Reset mid-GEN (cnt=3): outputs clear immediately
    do_start(16'h9000, 16'hFFF1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    last_d[0] = '0; last_d[1] = '0;
    chk_reset("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", wide_t'(s_if.ready), wide_t'(0));
    chk("post_rst_busy",  wide_t'(s_if.busy),  wide_t'(0));
    rd2(3'd1, 3'd1, 1'b1, 1'b1, 1'b0, '0, '0);
    do_start(16'h9000, 16'hFFF1);
    wait_done(20, cyc);
    chk("post_rst_done_lat", wide_t'(cyc), wide_t'(7));
    rd2(3'd3, 3'd7, 1'b1, 1'b1, 1'b1, 16'hB00F, 16'hF02D);
    rd2(3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 16'hF02D, 16'h0000);

    // Default-width table against k*B mod M computed by multiply-then-modulo
    l_if.base = Bl; l_if.modulus = Ml; l_if.start = 1'b1;
    tick();
    l_if.start = 1'b0;
    cyc = 0;
    while (!l_if.done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("wide_done_lat", wide_t'(cyc), wide_t'(31));
    for (int k = 0; k < 32; k++) begin
      l_if.rd_idx = 5'(k);
      l_if.rd_en  = 1'b1;
      sbq_l.push_back(gold(k));
      tick();
      l_if.rd_en = 1'b0;
      chk($sformatf("wide_vld%0d", k), wide_t'(l_if.rd_valid), wide_t'(1));
      chk($sformatf("wide_dat%0d", k), l_if.rd_data, sbq_l.pop_front());
    end
    tick();
    chk("wide_vld_idle", wide_t'(l_if.rd_valid), wide_t'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
